seq_divider_16by8: RTL and testbench
====================================

Name: seq_divider_16by8

Overview:
- Sequential radix-2 restoring divider. It computes a 16-bit dividend / 8-bit divisor and returns a 16-bit quotient and an 8-bit remainder.
- Works as the inverse of the 8x8 Dadda multiplier: dividing the multiplier product Y by B recovers A with zero remainder.
- Sits beside the multiplier in the arithmetic datapath.
- Uses valid/ready handshakes on both the input and output sides, one iteration per clock.

Parameters:
- DW, 16, dividend and quotient width
- VW, 8, divisor and remainder width

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept an operation
- dividend  input  DW  numerator, unsigned
- divisor  input  VW  denominator, unsigned
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder
- div_by_zero  output  1  result came from divisor==0

Behaviour:
- Clock and reset:
  - Single clock, clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset state:
  - state=IDLE.
  - in_ready=1.
  - out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal count=0 and partial remainder=0.
- Reset mid-operation:
  - Aborts immediately and discards the operation.
  - No out_valid pulse follows.
- States: IDLE, BUSY, DONE.
- in_ready = (state==IDLE). Only one operation is in flight; no overlap of accept with DONE.
- IDLE:
  - Operation is accepted on an edge where in_valid && in_ready.
  - Latch dividend into shift register Q and divisor into D; clear partial remainder R (VW+1 bits); count=0.
  - If divisor!=0: go to BUSY.
  - If divisor==0: go straight to DONE with quotient={DW{1}}, remainder=dividend[VW-1:0], div_by_zero=1.
- BUSY, each edge does one restoring step:
  - T = {R[VW-1:0], Q[DW-1]}, which is VW+1 bits.
  - If T >= {1'b0,D}: R=T-D and the shifted-in quotient bit is 1. Otherwise R=T and the bit is 0.
  - Q = {Q[DW-2:0], bit}.
  - count increments. After the DW-th step (count==DW-1 at the edge), go to DONE.
- Latency, with the acceptance edge as edge 0:
  - Normal operation: out_valid is high after edge DW (16). Accept-to-result latency is 16 cycles.
  - Divide-by-zero: out_valid is high after edge 0 (latency 1 cycle).
- DONE:
  - out_valid=1.
  - quotient=Q, remainder=R[VW-1:0], div_by_zero=flag.
  - All three outputs are held stable while out_valid && !out_ready.
  - On the edge where out_valid && out_ready: go to IDLE, out_valid=0. Data outputs keep their last values; they are don't-care when out_valid=0.
- in_valid during BUSY/DONE is ignored; in_ready=0, so no transfer occurs.
- Width rules:
  - Result is exact integer division: dividend == quotient*divisor + remainder, with remainder < divisor.
  - R never exceeds VW bits after the subtract; the MSB of R is a carry guard only.
- divisor==1 or dividend<divisor need no special-casing; the iteration handles them.

Decomposition:
- Shared package arith_pkg:
  - DW/VW default constants.
  - State enum typedef {IDLE,BUSY,DONE}.
  - Constant DIV0_QUOTIENT={DW{1}}.
- One natural sub-module, div_step: combinational, takes (R, next dividend bit, D) and gives (R_next, q_bit).
  - Instantiated once in the control module.
  - Allows later unrolling to radix-4 or two steps per cycle.

Test Plan:
- Basic: dividend=30, divisor=6 -> after 16 cycles out_valid=1, quotient=5, remainder=0, div_by_zero=0. This mirrors the 5*6=30 multiplier check.
- Extremes:
  - 65535/1 -> quotient=65535, remainder=0.
  - 1000/255 -> quotient=3, remainder=235.
  - 7/9 -> quotient=0, remainder=7.
- Divide by zero: dividend=0x0164, divisor=0 -> out_valid one cycle after accept, quotient=0xFFFF, remainder=0x64, div_by_zero=1.
- Backpressure:
  - Result 1000/255 ready; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0.
  - A new in_valid with 10/2 is not accepted.
  - Raise out_ready -> IDLE next cycle; 10/2 is then accepted and gives quotient=5, remainder=0.
- Reset mid-operation: assert rst at cycle 8 of 30/6 -> next cycle in_ready=1, out_valid=0, quotient=0, remainder=0, and no result appears afterwards.
- Round-trip: 256 random (A,B) with B!=0. Feed the multiplier output Y as dividend and B as divisor -> quotient==A, remainder==0. Back-to-back ops each take 16 + handshake cycles.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared widths, divider FSM states and divide-by-zero quotient
package arith_pkg;
  localparam int DIV_DW = 16;
  localparam int DIV_VW = 8;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  localparam logic [DIV_DW-1:0] DIV0_QUOTIENT = {DIV_DW{1'b1}};
endpackage

// File: rtl/seq_divider_16by8_div_step.sv
// div_step: one radix-2 restoring step (r, next dividend bit, d) -> (r_next, q_bit)
// Ports: r_i partial remainder, bit_i next dividend bit, d_i divisor,
//        r_next_o updated remainder, q_bit_o quotient bit
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] r_i,
  input  logic          bit_i,
  input  logic [VW-1:0] d_i,
  output logic [VW-1:0] r_next_o,
  output logic          q_bit_o
);
  logic [VW:0] t;
  assign t = {r_i, bit_i};
  assign q_bit_o = t >= {1'b0, d_i};
  // after a successful subtract the result always fits back into VW bits
  assign r_next_o = q_bit_o ? VW'(t - {1'b0, d_i}) : t[VW-1:0];
endmodule

// File: rtl/seq_divider_16by8.sv
// seq_divider_16by8: sequential radix-2 restoring divider, DW/VW unsigned, valid/ready on both sides
// Ports: clk/rst, in_valid/in_ready + dividend/divisor accept an operation,
//        out_valid/out_ready + quotient/remainder/div_by_zero return the result
module seq_divider_16by8 import arith_pkg::*; #(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  localparam int CW = $clog2(DW);
  div_state_e    state_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] d_q, r_q, r_d;
  logic [CW-1:0] cnt_q;
  logic          dz_q, q_bit_d;
  div_step #(.VW(VW)) u_step (
    .r_i      (r_q),
    .bit_i    (q_q[DW-1]),
    .d_i      (d_q),
    .r_next_o (r_d),
    .q_bit_o  (q_bit_d)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          d_q     <= divisor;
          cnt_q   <= '0;
          dz_q    <= divisor == '0;
          q_q     <= divisor == '0 ? '1 : dividend;
          r_q     <= divisor == '0 ? dividend[VW-1:0] : '0;
          state_q <= divisor == '0 ? DONE : BUSY;
        end
        BUSY: begin
          r_q     <= r_d;
          q_q     <= {q_q[DW-2:0], q_bit_d};
          cnt_q   <= cnt_q + 1'b1;
          state_q <= cnt_q == CW'(DW - 1) ? DONE : BUSY;
        end
        DONE: state_q <= out_ready ? IDLE : DONE;
        default: state_q <= IDLE;
      endcase
    end
  assign in_ready    = state_q == IDLE;
  assign out_valid   = state_q == DONE;
  assign quotient    = q_q;
  assign remainder   = r_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_divider_16by8.sv
// tb_seq_divider_16by8: directed and random checks of the divider against integer / and %
module tb_seq_divider_16by8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  seq_divider_16by8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic wait_result(input string tag, input int lat, input logic [15:0] eq,
                             input logic [7:0] er, input logic edz);
    int e = 0;
    while (out_valid !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
    end
    chk({tag, "_lat"}, e, lat);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_dz"}, div_by_zero, edz);
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  task automatic run_op(input string tag, input logic [15:0] a, input logic [7:0] b);
    send(a, b);
    if (b == 0) wait_result(tag, 0, 16'hFFFF, a[7:0], 1'b1);
    else wait_result(tag, 16, 16'(a / b), 8'(a % b), 1'b0);
    consume();
  endtask
  initial begin
    logic [15:0] hq, hr;
    int ov;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    run_op("basic_30_6", 16'd30, 8'd6);
    run_op("max_by_1", 16'd65535, 8'd1);
    run_op("1000_255", 16'd1000, 8'd255);
    run_op("7_9", 16'd7, 8'd9);
    send(16'h0164, 8'd0);
    wait_result("div0", 0, 16'hFFFF, 8'h64, 1'b1);
    consume();
    chk("div0_idle", in_ready, 1);
    // backpressure: hold the 1000/255 result while a 10/2 request waits
    send(16'd1000, 8'd255);
    wait_result("bp", 16, 16'd3, 8'd235, 1'b0);
    in_valid = 1'b1;
    dividend = 16'd10;
    divisor  = 8'd2;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_q", quotient, 3);
      chk("bp_hold_r", remainder, 235);
      chk("bp_in_ready", in_ready, 0);
    end
    consume();
    chk("bp_release_idle", in_ready, 1);
    chk("bp_release_ov", out_valid, 0);
    send(16'd10, 8'd2);
    wait_result("bp_next", 16, 16'd5, 8'd0, 1'b0);
    consume();
    // reset at cycle 8 of 30/6 must discard the operation
    send(16'd30, 8'd6);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    ov = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid === 1'b1) ov++;
    end
    chk("mid_rst_no_result", ov, 0);
    // round trip against multiplier products
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = 8'($urandom_range(1, 255));
      send(16'(a * b), b);
      wait_result("roundtrip", 16, {8'd0, a}, 8'd0, 1'b0);
      consume();
    end
    // arbitrary dividends including occasional zero divisors
    for (int i = 0; i < 40; i++) begin
      hq = 16'($urandom);
      hr = 16'($urandom_range(0, 255));
      run_op("random", hq, hr[7:0]);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
